// File: rtl/cpc_z80_bus_master.sv
// CPC expansion-bus Z80 cycle initiator: turns valid/ready requests into memory, M1+refresh
// and IO bus cycles with READY wait states, a wait timeout and a registered response port.
module cpc_z80_bus_master #(
   parameter int unsigned WAIT_MAX = 16,
   parameter logic [6:0]  R_INIT   = 7'h00
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_type,
   input  logic        req_m1,
   input  logic [15:0] req_adr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [15:0] adr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   output logic        mreq_b,
   output logic        iorq_b,
   output logic        rd_b,
   output logic        wr_b,
   output logic        m1_b,
   output logic        rfsh_b,
   input  logic        ready
);

   typedef enum logic [3:0] {
      S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_RF1, S_RF2, S_DONE
   } state_t;

   localparam logic [1:0] TYPE_MEM_RD = 2'b00;
   localparam logic [1:0] TYPE_IO_RD  = 2'b11;
   localparam logic [7:0] WCNT_LAST   = 8'(WAIT_MAX - 1);

   state_t      state_q, state_d;
   logic [1:0]  type_q, type_d;
   logic        m1_q, m1_d;
   logic [15:0] adr_req_q, adr_req_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic [6:0]  r_q, r_d;
   logic        abort_q, abort_d;
   logic [7:0]  rdata_q, rdata_d;

   logic        rdy_q, rdy_d;
   logic        rspv_q, rspv_d;
   logic        rsperr_q, rsperr_d;
   logic [15:0] adr_q, adr_d;
   logic [7:0]  dout_q, dout_d;
   logic        oe_q, oe_d;
   logic        mreq_b_q, mreq_b_d;
   logic        iorq_b_q, iorq_b_d;
   logic        rd_b_q, rd_b_d;
   logic        wr_b_q, wr_b_d;
   logic        m1_b_q, m1_b_d;
   logic        rfsh_b_q, rfsh_b_d;

   logic        cur_is_io, cur_is_rd, cur_fetch;
   logic        nxt_is_io, nxt_is_rd, nxt_fetch;
   logic        nxt_strobe, nxt_cycle, nxt_rfsh;

   assign cur_is_io = type_q[1];
   assign cur_is_rd = (type_q == TYPE_MEM_RD) || (type_q == TYPE_IO_RD);
   assign cur_fetch = (type_q == TYPE_MEM_RD) && m1_q;

   // Sequencer: one state per clock; request fields are captured only on the accept edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d   = state_q;
      type_d    = type_q;
      m1_d      = m1_q;
      adr_req_d = adr_req_q;
      wdata_d   = wdata_q;
      wcnt_d    = wcnt_q;
      r_d       = r_q;
      abort_d   = abort_q;
      rdata_d   = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               type_d    = req_type;
               m1_d      = req_m1;
               adr_req_d = req_adr;
               wdata_d   = req_wdata;
               abort_d   = 1'b0;
               state_d   = S_T1;
            end
         end
         S_T1: begin
            wcnt_d  = 8'd0;
            state_d = S_T2;
         end
         S_T2: begin
            if (cur_is_io)  state_d = S_TWA;
            else if (ready) state_d = S_T3;
            else            state_d = S_TW;
         end
         S_TWA:  state_d = ready ? S_T3 : S_TW;
         S_TW: begin
            if (ready) begin
               state_d = S_T3;
            end else if (wcnt_q == WCNT_LAST) begin
               abort_d = 1'b1;
               state_d = S_DONE;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         S_T3: begin
            if (cur_is_rd) rdata_d = data_in;
            state_d = cur_fetch ? S_RF1 : S_DONE;
         end
         S_RF1:  state_d = S_RF2;
         S_RF2: begin
            r_d     = r_q + 7'd1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign nxt_is_io  = type_d[1];
   assign nxt_is_rd  = (type_d == TYPE_MEM_RD) || (type_d == TYPE_IO_RD);
   assign nxt_fetch  = (type_d == TYPE_MEM_RD) && m1_d;
   assign nxt_strobe = (state_d == S_T2) || (state_d == S_TWA) || (state_d == S_TW) || (state_d == S_T3);
   assign nxt_cycle  = (state_d == S_T1) || nxt_strobe;
   assign nxt_rfsh   = (state_d == S_RF1) || (state_d == S_RF2);

   // Bus outputs are decoded from the upcoming state and loaded into flops, so pins never glitch.
   always_comb begin
      rdy_d    = (state_d == S_IDLE);
      rspv_d   = (state_d == S_DONE);
      rsperr_d = (state_d == S_DONE) && abort_d;
      mreq_b_d = !((nxt_strobe && !nxt_is_io) || nxt_rfsh);
      iorq_b_d = !(nxt_strobe && nxt_is_io);
      rd_b_d   = !(nxt_strobe && nxt_is_rd);
      wr_b_d   = !(nxt_strobe && !nxt_is_rd);
      m1_b_d   = !(nxt_cycle && nxt_fetch);
      rfsh_b_d = !nxt_rfsh;
      oe_d     = nxt_cycle && !nxt_is_rd;
      adr_d    = adr_q;
      dout_d   = dout_q;
      if (state_d == S_T1) begin
         adr_d = adr_req_d;
         if (!nxt_is_rd) dout_d = wdata_d;
      end else if (nxt_rfsh) begin
         adr_d = {9'h000, r_q};
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= S_IDLE;
         type_q    <= 2'b00;
         m1_q      <= 1'b0;
         adr_req_q <= 16'h0000;
         wdata_q   <= 8'h00;
         wcnt_q    <= 8'd0;
         r_q       <= R_INIT;
         abort_q   <= 1'b0;
         rdata_q   <= 8'h00;
         rdy_q     <= 1'b1;
         rspv_q    <= 1'b0;
         rsperr_q  <= 1'b0;
         adr_q     <= 16'h0000;
         dout_q    <= 8'h00;
         oe_q      <= 1'b0;
         mreq_b_q  <= 1'b1;
         iorq_b_q  <= 1'b1;
         rd_b_q    <= 1'b1;
         wr_b_q    <= 1'b1;
         m1_b_q    <= 1'b1;
         rfsh_b_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q   <= state_d;
         type_q    <= type_d;
         m1_q      <= m1_d;
         adr_req_q <= adr_req_d;
         wdata_q   <= wdata_d;
         wcnt_q    <= wcnt_d;
         r_q       <= r_d;
         abort_q   <= abort_d;
         rdata_q   <= rdata_d;
         rdy_q     <= rdy_d;
         rspv_q    <= rspv_d;
         rsperr_q  <= rsperr_d;
         adr_q     <= adr_d;
         dout_q    <= dout_d;
         oe_q      <= oe_d;
         mreq_b_q  <= mreq_b_d;
         iorq_b_q  <= iorq_b_d;
         rd_b_q    <= rd_b_d;
         wr_b_q    <= wr_b_d;
         m1_b_q    <= m1_b_d;
         rfsh_b_q  <= rfsh_b_d;
      end
   end

   assign req_ready = rdy_q;
   assign rsp_valid = rspv_q;
   assign rsp_err   = rsperr_q;
   assign rsp_rdata = rdata_q;
   assign adr       = adr_q;
   assign data_out  = dout_q;
   assign data_oe   = oe_q;
   assign mreq_b    = mreq_b_q;
   assign iorq_b    = iorq_b_q;
   assign rd_b      = rd_b_q;
   assign wr_b      = wr_b_q;
   assign m1_b      = m1_b_q;
   assign rfsh_b    = rfsh_b_q;

endmodule

// File: tb/tb_cpc_z80_bus_master.sv
// Directed bench for cpc_z80_bus_master: expected responses and strobe widths are queued when a
// request is driven and compared when rsp_valid arrives; bus rules are checked every cycle.
module tb_cpc_z80_bus_master;

   localparam int unsigned WAIT_MAX = 16;
   localparam logic [6:0]  R_INIT   = 7'h7F;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_type;
   logic        req_m1;
   logic [15:0] req_adr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [15:0] adr;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [7:0]  data_in;
   logic        mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b;
   logic        ready;

   cpc_z80_bus_master #(.WAIT_MAX(WAIT_MAX), .R_INIT(R_INIT)) dut (
      .clk(clk), .reset_b(reset_b),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_m1(req_m1),
      .req_adr(req_adr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .adr(adr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
      .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b), .rfsh_b(rfsh_b),
      .ready(ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      logic       fetch;
      int         lat, mreq, iorq, rd, wr, m1, rfsh, oe;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [6:0] r_model = R_INIT;
   logic [7:0] last_rdata = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected cycle shape from the bus-cycle definition: w = number of TW states.
   function automatic exp_t model(input logic [1:0] t, input logic m1, input int w,
                                  input logic abort, input logic [7:0] din);
      exp_t e;
      logic is_io = t[1];
      logic is_rd = (t == 2'b00) || (t == 2'b11);
      logic fetch = (t == 2'b00) && m1;
      int   dur;
      dur     = is_io ? (abort ? 2 + w : 3 + w) : (abort ? 1 + w : 2 + w);
      e.fetch = fetch && !abort;
      e.err   = abort;
      e.rdata = (is_rd && !abort) ? din : last_rdata;
      e.lat   = abort ? ((is_io ? 4 : 3) + w) : ((is_io ? 5 : (fetch ? 6 : 4)) + w);
      e.mreq  = is_io ? 0 : dur + (e.fetch ? 2 : 0);
      e.iorq  = is_io ? dur : 0;
      e.rd    = is_rd ? dur : 0;
      e.wr    = is_rd ? 0 : dur;
      e.m1    = fetch ? 3 + w : 0;
      e.rfsh  = e.fetch ? 2 : 0;
      e.oe    = is_rd ? 0 : dur + 1;
      return e;
   endfunction

   task automatic run_req(input string name, input logic [1:0] t, input logic m1,
                          input logic [15:0] a, input logic [7:0] wd, input logic [7:0] din,
                          input int rdy_from, input int rdy_n, input int w, input logic abort,
                          input bit keep_valid, output int idle_wait);
      exp_t e, got_e;
      int   n_mreq = 0, n_iorq = 0, n_rd = 0, n_wr = 0, n_m1 = 0, n_rfsh = 0, n_oe = 0;
      int   n_ovl = 0, n_adr_bad = 0, n_dout_bad = 0, n_radr_bad = 0;
      int   lat = 0;
      bit   got = 0;
      req_type  = t;
      req_m1    = m1;
      req_adr   = a;
      req_wdata = wd;
      req_valid = 1'b1;
      data_in   = din;
      e = model(t, m1, w, abort, din);
      sb.push_back(e);
      last_rdata = e.rdata;
      idle_wait = 0;
      while (req_ready !== 1'b1 && idle_wait < 50) begin
         @(negedge clk);
         idle_wait++;
      end
      if (req_ready !== 1'b1) begin
         check($sformatf("%s_accept_timeout", name), 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         void'(sb.pop_front());
         return;
      end
      @(posedge clk);
      #1;
      if (!keep_valid) req_valid = 1'b0;
      req_adr   = ~a;
      req_wdata = ~wd;
      req_m1    = ~m1;
      for (int c = 1; c <= 64 && !got; c++) begin
         @(negedge clk);
         ready = !(c >= rdy_from && c < rdy_from + rdy_n);
         if (c == 1) check($sformatf("%s_ready_busy", name), 32'(req_ready), 32'd0);
         if (!mreq_b) n_mreq++;
         if (!iorq_b) n_iorq++;
         if (!rd_b)   n_rd++;
         if (!wr_b)   n_wr++;
         if (!m1_b)   n_m1++;
         if (!rfsh_b) n_rfsh++;
         if (data_oe) n_oe++;
         if ((!mreq_b && !iorq_b) || (!rd_b && !wr_b)) n_ovl++;
         if ((c == 1 || (rfsh_b && (!mreq_b || !iorq_b))) && adr !== a) n_adr_bad++;
         if (!rfsh_b && adr !== {9'h000, r_model}) n_radr_bad++;
         if (data_oe && data_out !== wd) n_dout_bad++;
         if (rsp_valid) begin
            got = 1;
            lat = c;
         end
      end
      ready = 1'b1;
      if (!got) begin
         check($sformatf("%s_rsp_timeout", name), 32'd0, 32'd1);
         void'(sb.pop_front());
         return;
      end
      got_e = sb.pop_front();
      check($sformatf("%s_latency", name), 32'(lat), 32'(got_e.lat));
      check($sformatf("%s_rdata", name),   32'(rsp_rdata), 32'(got_e.rdata));
      check($sformatf("%s_err", name),     32'(rsp_err), 32'(got_e.err));
      check($sformatf("%s_mreq_w", name),  32'(n_mreq), 32'(got_e.mreq));
      check($sformatf("%s_iorq_w", name),  32'(n_iorq), 32'(got_e.iorq));
      check($sformatf("%s_rd_w", name),    32'(n_rd), 32'(got_e.rd));
      check($sformatf("%s_wr_w", name),    32'(n_wr), 32'(got_e.wr));
      check($sformatf("%s_m1_w", name),    32'(n_m1), 32'(got_e.m1));
      check($sformatf("%s_rfsh_w", name),  32'(n_rfsh), 32'(got_e.rfsh));
      check($sformatf("%s_oe_w", name),    32'(n_oe), 32'(got_e.oe));
      check($sformatf("%s_overlap", name), 32'(n_ovl), 32'd0);
      check($sformatf("%s_adr", name),     32'(n_adr_bad), 32'd0);
      check($sformatf("%s_rfsh_adr", name), 32'(n_radr_bad), 32'd0);
      check($sformatf("%s_dout", name),    32'(n_dout_bad), 32'd0);
      check($sformatf("%s_strobes_done", name),
            32'({mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b, data_oe}), 32'h7E);
      if (got_e.fetch) r_model = r_model + 7'd1;
   endtask

   initial begin
      int iw;
      reset_b   = 1'b0;
      req_valid = 1'b0;
      req_type  = 2'b00;
      req_m1    = 1'b0;
      req_adr   = 16'h0000;
      req_wdata = 8'h00;
      data_in   = 8'h00;
      ready     = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_strobes", 32'({mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b}), 32'h3F);
      check("rst_adr", 32'(adr), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_data_oe", 32'(data_oe), 32'd0);
      check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'd0);

      run_req("io_wr_bank", 2'b10, 1'b0, 16'h7F00, 8'hC4, 8'h00, 0, 0, 0, 1'b0, 0, iw);
      run_req("mem_rd_wait", 2'b00, 1'b0, 16'h4000, 8'h00, 8'hA5, 2, 2, 2, 1'b0, 0, iw);
      run_req("fetch_a", 2'b00, 1'b1, 16'h0100, 8'h00, 8'h3E, 0, 0, 0, 1'b0, 0, iw);
      run_req("fetch_b", 2'b00, 1'b1, 16'h0101, 8'h00, 8'h77, 0, 0, 0, 1'b0, 0, iw);
      run_req("mem_wr_tmo", 2'b01, 1'b0, 16'h8000, 8'h5A, 8'h00, 2, 100, WAIT_MAX, 1'b1, 0, iw);
      run_req("io_rd_wait", 2'b11, 1'b0, 16'h7E00, 8'h00, 8'h99, 3, 3, 3, 1'b0, 0, iw);

      run_req("b2b_wr", 2'b01, 1'b1, 16'hC000, 8'h11, 8'h00, 0, 0, 0, 1'b0, 1, iw);
      run_req("b2b_rd", 2'b00, 1'b0, 16'hC001, 8'h00, 8'h22, 0, 0, 0, 1'b0, 0, iw);
      check("b2b_idle_cycles", 32'(iw), 32'd1);

      // Asynchronous reset while an IO read sits in TW.
      req_type  = 2'b11;
      req_m1    = 1'b0;
      req_adr   = 16'h7F10;
      req_valid = 1'b1;
      data_in   = 8'hEE;
      iw = 0;
      while (req_ready !== 1'b1 && iw < 50) begin
         @(negedge clk);
         iw++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         ready = (c >= 2) ? 1'b0 : 1'b1;
      end
      check("rst_mid_iorq_active", 32'({iorq_b, rd_b}), 32'd0);
      #2 reset_b = 1'b0;
      #1;
      check("rst_mid_strobes", 32'({mreq_b, iorq_b, rd_b, wr_b, m1_b, rfsh_b}), 32'h3F);
      check("rst_mid_rsp", 32'({rsp_valid, data_oe}), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
      end
      reset_b    = 1'b1;
      ready      = 1'b1;
      r_model    = R_INIT;
      last_rdata = 8'h00;
      @(negedge clk);
      check("rst_rel_ready", 32'(req_ready), 32'd1);
      check("rst_rel_rsp", 32'(rsp_valid), 32'd0);
      check("rst_rel_rdata", 32'(rsp_rdata), 32'd0);
      run_req("fetch_post_rst", 2'b00, 1'b1, 16'h0200, 8'h00, 8'h12, 0, 0, 0, 1'b0, 0, iw);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
